// File: rtl/mac_pkg.sv
// Shared MAC datapath types and width helpers.
// Used by the carry_save_resolver slice.
package mac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } csr_state_t;

  function automatic int csr_width(input int parm_mant);
    return 2 * parm_mant + 3;
  endfunction

  function automatic int csr_beats(input int w, input int chunk);
    return (w + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/carry_save_resolver_if.sv
// Input pair / result handshake bundle for carry_save_resolver.
// zero_o exists only when CSR_ZERO_DETECT_EN is defined.
interface carry_save_resolver_if #(
  parameter int W = 49
);
  logic         in_valid_i;
  logic         in_ready_o;
  logic [W-1:0] wallace_sum_i;
  logic [W-1:0] wallace_carry_i;
  logic         suppression_sign_extension_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [W-1:0] product_o;
  logic         carry_out_o;
`ifdef CSR_ZERO_DETECT_EN
  logic         zero_o;
`endif

  modport master (
    output in_valid_i,
    output wallace_sum_i,
    output wallace_carry_i,
    output suppression_sign_extension_i,
    output out_ready_i,
    input  in_ready_o,
    input  out_valid_o,
    input  product_o,
`ifdef CSR_ZERO_DETECT_EN
    input  zero_o,
`endif
    input  carry_out_o
  );

  modport slave (
    input  in_valid_i,
    input  wallace_sum_i,
    input  wallace_carry_i,
    input  suppression_sign_extension_i,
    input  out_ready_i,
    output in_ready_o,
    output out_valid_o,
    output product_o,
`ifdef CSR_ZERO_DETECT_EN
    output zero_o,
`endif
    output carry_out_o
  );

endinterface

// File: rtl/csr_chunk_adder.sv
// One CHUNK-bit slice of the resolver's carry-propagate add.
// On the final beat only LAST bits are live; cout taps bit LAST.
module csr_chunk_adder #(
  parameter int CHUNK = 16,
  parameter int LAST  = 16
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  input  logic             last_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  localparam logic [CHUNK-1:0] LAST_MASK =
    {CHUNK{1'b1}} >> (CHUNK - LAST);

  logic [CHUNK:0] full;

  assign full = {1'b0, a_i} + {1'b0, b_i}
              + {{CHUNK{1'b0}}, cin_i};

  assign sum_o  = last_i ? (full[CHUNK-1:0] & LAST_MASK)
                         : full[CHUNK-1:0];
  assign cout_o = last_i ? full[LAST] : full[CHUNK];

endmodule

// File: rtl/carry_save_resolver.sv
// Multi-cycle CPA resolving a carry-save pair CHUNK bits per beat.
// Define CSR_ZERO_DETECT_EN to add the sticky zero_o flag.
module carry_save_resolver
  import mac_pkg::*;
#(
  parameter int PARM_MANT = 23,
  parameter int CHUNK     = 16
) (
  input logic                  clk_i,
  input logic                  rst_i,
  carry_save_resolver_if.slave bus
);

  localparam int W    = csr_width(PARM_MANT);
  localparam int N    = csr_beats(W, CHUNK);
  localparam int KW   = (N > 1) ? $clog2(N) : 1;
  localparam int LAST = W - (N - 1) * CHUNK;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  csr_state_t    state;
  logic [KW-1:0] k;
  logic [W-1:0]  sum_q;
  logic [W-1:0]  carry_q;
  logic          sup_q;
  logic          cc_q;

  wire  [CHUNK-1:0] a_arr [N];
  wire  [CHUNK-1:0] b_arr [N];
  wire  [W-1:0]     prod_w;
  logic [CHUNK-1:0] s;
  logic             cout;
  logic             last;
  logic             accept;
  logic             step;

  assign accept = (state == IDLE) && bus.in_valid_i;
  assign step   = (state == ADD);
  assign last   = (k == K_LAST);

  csr_chunk_adder #(
    .CHUNK (CHUNK),
    .LAST  (LAST)
  ) u_add (
    .a_i    (a_arr[k]),
    .b_i    (b_arr[k]),
    .cin_i  (cc_q),
    .last_i (last),
    .sum_o  (s),
    .cout_o (cout)
  );

  // Each beat owns a fixed product slice; the last may be narrow.
  for (genvar c = 0; c < N; c++) begin : g_beat
    localparam int LO = c * CHUNK;
    localparam int HI = (LO + CHUNK > W) ? W - 1 : LO + CHUNK - 1;

    logic [HI-LO:0] r;

    assign a_arr[c] = CHUNK'(sum_q[HI:LO]);
    assign b_arr[c] = CHUNK'(carry_q[HI:LO]);
    assign prod_w[HI:LO] = r;

    always_ff @(posedge clk_i) begin
      if (rst_i || accept) begin
        r <= '0;
      end else if (step && k == KW'(c)) begin
        r <= s[HI-LO:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      k       <= '0;
      sum_q   <= '0;
      carry_q <= '0;
      sup_q   <= 1'b0;
      cc_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid_i) begin
            sum_q   <= bus.wallace_sum_i;
            carry_q <= bus.wallace_carry_i;
            sup_q   <= bus.suppression_sign_extension_i;
            k       <= '0;
            cc_q    <= 1'b0;
            state   <= ADD;
          end
        end
        ADD: begin
          cc_q <= cout;
          if (last) begin
            k     <= '0;
            state <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (bus.out_ready_i) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CSR_ZERO_DETECT_EN
  logic zero_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      zero_q <= 1'b0;
    end else if (accept) begin
      zero_q <= 1'b1;
    end else if (step) begin
      zero_q <= zero_q & ~|s;
    end
  end

  assign bus.zero_o = (state == DONE) & zero_q;
`endif

  assign bus.in_ready_o  = (state == IDLE);
  assign bus.out_valid_o = (state == DONE);
  assign bus.product_o   = prod_w;
  assign bus.carry_out_o = cc_q & ~sup_q;

endmodule

// File: tb/tb_carry_save_resolver.sv
// Directed bench for carry_save_resolver with a cycle-level model.
// Build with/without CSR_ZERO_DETECT_EN; zero_o is checked only when defined.
module tb_carry_save_resolver;

  localparam int PM = 23;
  localparam int W  = 2 * PM + 3;
  localparam int CH = 16;
  localparam int N  = (W + CH - 1) / CH;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  carry_save_resolver_if #(.W(W)) bus ();

  carry_save_resolver #(
    .PARM_MANT (PM),
    .CHUNK     (CH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: result is plain (sum+carry) mod 2^W, visible N edges after accept.
  bit           m_busy = 0;
  bit           m_done = 0;
  int           m_beats = 0;
  logic [W-1:0] pend_p, exp_p = '0;
  logic         pend_c, exp_c = 1'b0;
  logic         pend_z, exp_z = 1'b0;

  always @(posedge clk) begin
    logic [W:0] full;
    if (rst) begin
      m_busy = 0;
      m_done = 0;
      exp_p  = '0;
      exp_c  = 1'b0;
      exp_z  = 1'b0;
    end else if (m_busy) begin
      m_beats++;
      if (m_beats == N) begin
        m_busy = 0;
        m_done = 1;
        exp_p  = pend_p;
        exp_c  = pend_c;
        exp_z  = pend_z;
      end
    end else if (m_done) begin
      if (bus.out_ready_i) m_done = 0;
    end else if (bus.in_valid_i) begin
      full    = {1'b0, bus.wallace_sum_i} + {1'b0, bus.wallace_carry_i};
      pend_p  = full[W-1:0];
      pend_c  = full[W] & ~bus.suppression_sign_extension_i;
      pend_z  = (full[W-1:0] == '0);
      m_busy  = 1;
      m_beats = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", bus.in_ready_o, !m_busy && !m_done);
      chk("out_valid", bus.out_valid_o, m_done);
      if (!m_busy) begin
        chk("product", bus.product_o, exp_p);
        chk("carry_out", bus.carry_out_o, exp_c);
      end
`ifdef CSR_ZERO_DETECT_EN
      chk("zero", bus.zero_o, m_done && exp_z);
`endif
    end
  end

  task automatic send(input logic [W-1:0] s,
                      input logic [W-1:0] c,
                      input logic sup);
    int n = 0;
    while (!bus.in_ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n == 20) begin
      errors++;
      $display("FAIL send_timeout: in_ready stuck at %b", bus.in_ready_o);
    end
    bus.in_valid_i = 1'b1;
    bus.wallace_sum_i = s;
    bus.wallace_carry_i = c;
    bus.suppression_sign_extension_i = sup;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.out_valid_o) begin
      errors++;
      $display("FAIL done_timeout: out_valid %b after %0d cycles",
               bus.out_valid_o, lat);
    end
  endtask

  task automatic expect_res(input string tag,
                            input logic [W-1:0] ep,
                            input logic ec,
                            input logic ez);
    chk({tag, "_prod"}, bus.product_o, ep);
    chk({tag, "_cout"}, bus.carry_out_o, ec);
`ifdef CSR_ZERO_DETECT_EN
    chk({tag, "_zero"}, bus.zero_o, ez);
`else
    if (ez) checks += 0;
`endif
  endtask

  task automatic release_out();
    bus.out_ready_i = 1'b1;
    @(negedge clk);
    bus.out_ready_i = 1'b0;
    chk("rel_in_ready", bus.in_ready_o, 1'b1);
  endtask

  task automatic op(input string tag,
                    input logic [W-1:0] s,
                    input logic [W-1:0] c,
                    input logic sup,
                    input logic [W-1:0] ep,
                    input logic ec,
                    input logic ez);
    int lat;
    send(s, c, sup);
    wait_done(lat);
    chk({tag, "_lat"}, W'(lat), W'(N));
    expect_res(tag, ep, ec, ez);
    release_out();
  endtask

  initial begin
    int lat;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.wallace_sum_i = '0;
    bus.wallace_carry_i = '0;
    bus.suppression_sign_extension_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready_o, 1'b1);
    chk("rst_out_valid", bus.out_valid_o, 1'b0);
    chk("rst_prod", bus.product_o, '0);
    chk("rst_cout", bus.carry_out_o, 1'b0);

    op("basic", 49'h1, 49'h1, 1'b0, 49'h2, 1'b0, 1'b0);
    op("ripple", 49'h0_FFFF_FFFF_FFFF, 49'h1, 1'b0,
       49'h1_0000_0000_0000, 1'b0, 1'b0);
    op("ovf", 49'h1_FFFF_FFFF_FFFF, 49'h1, 1'b0, 49'h0, 1'b1, 1'b1);
    op("ovf_sup", 49'h1_FFFF_FFFF_FFFF, 49'h1, 1'b1, 49'h0, 1'b0, 1'b1);
    op("chunk", 49'h0_0000_0000_FFFF, 49'h1, 1'b0,
       49'h0_0000_0001_0000, 1'b0, 1'b0);
    op("zeros", 49'h0, 49'h0, 1'b0, 49'h0, 1'b0, 1'b1);
    op("msb", 49'h1_8000_0000_0000, 49'h1_8000_0000_0000, 1'b0,
       49'h1_0000_0000_0000, 1'b1, 1'b0);

    // Backpressure with a second pair waiting.
    send(49'h0_0000_0000_00FF, 49'h0_0000_0000_0001, 1'b0);
    wait_done(lat);
    bus.in_valid_i = 1'b1;
    bus.wallace_sum_i = 49'h0_1111_2222_3333;
    bus.wallace_carry_i = 49'h0_0001_0001_0001;
    bus.suppression_sign_extension_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready_o, 1'b0);
      chk("bp_valid", bus.out_valid_o, 1'b1);
      chk("bp_prod", bus.product_o, 49'h100);
    end
    release_out();
    @(posedge clk);
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    wait_done(lat);
    chk("bp2_lat", W'(lat), W'(N));
    expect_res("bp2", 49'h0_1112_2223_3334, 1'b0, 1'b0);
    release_out();

    // Reset after two ADD beats.
    send(49'h1_FFFF_0000_1234, 49'h0_0000_FFFF_0001, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_valid", bus.out_valid_o, 1'b0);
    chk("mid_rst_ready", bus.in_ready_o, 1'b1);
    chk("mid_rst_prod", bus.product_o, '0);
    op("post_rst", 49'h1234, 49'h0FF0, 1'b0, 49'h2224, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
